// File: rtl/bdf_sched_seq.sv
// Schedule sequencer: holds an ITER_PERIOD-deep table of control words and replays
// it cyclically as per-buffer write/read ping-pong toggle pulses.
module bdf_sched_seq #(
  parameter int unsigned NUM_BUFFS   = 12,
  parameter int unsigned CTRL_WIDTH  = NUM_BUFFS * 2,
  parameter int unsigned ITER_PERIOD = 48,
  parameter int unsigned MAX_ITERS   = 0,
  parameter int unsigned STEP_W      = $clog2(ITER_PERIOD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_ctrl,
  input  logic                  start_ctrl,
  input  logic                  stop_ctrl,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic [NUM_BUFFS-1:0]  buff_wr_toggle,
  output logic [NUM_BUFFS-1:0]  buff_rd_toggle,
  output logic [STEP_W-1:0]     step,
  output logic [15:0]           iter_cnt,
  output logic                  busy,
  output logic                  table_valid,
  output logic                  cmd_err
);

  localparam int unsigned        CNT_W     = 16;
  localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(ITER_PERIOD - 1);
  localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_ITERS);
  localparam bit                 BOUNDED   = (MAX_ITERS != 0);
  localparam logic [CNT_W-1:0]   CNT_SAT   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STOPPING
  } state_t;

  state_t                 state_q, state_d;
  logic [STEP_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [STEP_W-1:0]      rd_idx_q, rd_idx_d;
  logic [STEP_W-1:0]      step_d;
  logic [CNT_W-1:0]       iter_d;
  logic [CNT_W-1:0]       iter_inc;
  logic [NUM_BUFFS-1:0]   wr_tog_d, rd_tog_d;
  logic [NUM_BUFFS-1:0]   word_wr, word_rd;
  logic                   busy_d, valid_d, err_d;
  logic                   tbl_we;
  logic [STEP_W-1:0]      tbl_waddr;
  logic [CTRL_WIDTH-1:0]  tbl_word;

  // Schedule storage; contents are meaningful only while table_valid is set.
  logic [CTRL_WIDTH-1:0]  sched_mem [ITER_PERIOD];

  always_ff @(posedge clk) begin
    if (tbl_we) sched_mem[tbl_waddr] <= ctrl_in;
  end

  assign tbl_word = sched_mem[rd_idx_q];

  // Even bits drive write-side toggles, odd bits read-side toggles.
  for (genvar g = 0; g < NUM_BUFFS; g++) begin : g_split
    assign word_wr[g] = tbl_word[2*g];
    assign word_rd[g] = tbl_word[2*g+1];
  end

  assign iter_inc = (iter_cnt == CNT_SAT) ? iter_cnt : iter_cnt + CNT_W'(1);

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_idx_d  = rd_idx_q;
    step_d    = step;
    iter_d    = iter_cnt;
    wr_tog_d  = '0;
    rd_tog_d  = '0;
    valid_d   = table_valid;
    err_d     = cmd_err;
    tbl_we    = 1'b0;
    tbl_waddr = wr_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (stop_ctrl) begin
          state_d = S_IDLE;
        end else if (load_ctrl) begin
          tbl_we    = 1'b1;
          tbl_waddr = '0;
          wr_ptr_d  = STEP_W'(1);
          valid_d   = 1'b0;
          state_d   = S_LOAD;
        end else if (start_ctrl) begin
          if (table_valid) begin
            rd_idx_d = '0;
            step_d   = '0;
            iter_d   = '0;
            state_d  = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (stop_ctrl) begin
          wr_ptr_d = '0;
          state_d  = S_IDLE;
        end else begin
          if (start_ctrl) err_d = 1'b1;
          if (load_ctrl) begin
            tbl_we = 1'b1;
            if (wr_ptr_q == LAST_STEP) begin
              valid_d  = 1'b1;
              wr_ptr_d = '0;
              state_d  = S_IDLE;
            end else begin
              wr_ptr_d = wr_ptr_q + STEP_W'(1);
            end
          end
        end
      end

      S_RUN, S_STOPPING: begin
        wr_tog_d = word_wr;
        rd_tog_d = word_rd;
        step_d   = rd_idx_q;
        if (load_ctrl) err_d = 1'b1;
        if (rd_idx_q == LAST_STEP) begin
          // Iteration boundary: the only place a run may end without reset.
          rd_idx_d = '0;
          iter_d   = iter_inc;
          if ((state_q == S_STOPPING) || stop_ctrl || (BOUNDED && (iter_inc == MAX_CNT)))
            state_d = S_IDLE;
        end else begin
          rd_idx_d = rd_idx_q + STEP_W'(1);
          if ((state_q == S_RUN) && stop_ctrl) state_d = S_STOPPING;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_STOPPING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_idx_q       <= '0;
      step           <= '0;
      iter_cnt       <= '0;
      buff_wr_toggle <= '0;
      buff_rd_toggle <= '0;
      busy           <= 1'b0;
      table_valid    <= 1'b0;
      cmd_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_idx_q       <= rd_idx_d;
      step           <= step_d;
      iter_cnt       <= iter_d;
      buff_wr_toggle <= wr_tog_d;
      buff_rd_toggle <= rd_tog_d;
      busy           <= busy_d;
      table_valid    <= valid_d;
      cmd_err        <= err_d;
    end
  end

endmodule

// File: tb/tb_bdf_sched_seq.sv
// Directed bench for bdf_sched_seq: an unbounded instance (dut_a) and a
// MAX_ITERS=2 instance (dut_b) share one stimulus stream.
module tb_bdf_sched_seq;

  localparam int unsigned NB = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned IP = 4;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_ctrl, start_ctrl, stop_ctrl;
  logic [CW-1:0] ctrl_in;
  logic [NB-1:0] wr_a, rd_a, wr_b, rd_b;
  logic [SW-1:0] step_a, step_b;
  logic [15:0]   iter_a, iter_b;
  logic          busy_a, busy_b, valid_a, valid_b, err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bdf_sched_seq #(.NUM_BUFFS(NB), .CTRL_WIDTH(CW), .ITER_PERIOD(IP), .MAX_ITERS(0), .STEP_W(SW)) dut_a (
    .clk(clk), .rst(rst), .load_ctrl(load_ctrl), .start_ctrl(start_ctrl), .stop_ctrl(stop_ctrl),
    .ctrl_in(ctrl_in), .buff_wr_toggle(wr_a), .buff_rd_toggle(rd_a), .step(step_a),
    .iter_cnt(iter_a), .busy(busy_a), .table_valid(valid_a), .cmd_err(err_a)
  );

  bdf_sched_seq #(.NUM_BUFFS(NB), .CTRL_WIDTH(CW), .ITER_PERIOD(IP), .MAX_ITERS(2), .STEP_W(SW)) dut_b (
    .clk(clk), .rst(rst), .load_ctrl(load_ctrl), .start_ctrl(start_ctrl), .stop_ctrl(stop_ctrl),
    .ctrl_in(ctrl_in), .buff_wr_toggle(wr_b), .buff_rd_toggle(rd_b), .step(step_b),
    .iter_cnt(iter_b), .busy(busy_b), .table_valid(valid_b), .cmd_err(err_b)
  );

  typedef struct {
    logic        stop;
    logic [1:0]  wr;
    logic [1:0]  rd;
    logic [1:0]  stp;
    logic [15:0] iter;
    logic        bsy;
    logic        chk_stp;
    logic        chk_bsy;
  } vec_t;

  vec_t       vecs [13];
  logic [1:0] exp_wr [4];
  logic [1:0] exp_rd [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] w);
    load_ctrl = 1'b1;
    ctrl_in   = w;
    tick();
    load_ctrl = 1'b0;
    ctrl_in   = '0;
  endtask

  task automatic load_table();
    load_word(4'h1);
    load_word(4'h2);
    load_word(4'h4);
    load_word(4'h8);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start_ctrl = 1'b1;
    tick();
    start_ctrl = 1'b0;
  endtask

  task automatic check_word(input string name, input int idx);
    check({name, "_wr"}, 32'(wr_a), 32'(exp_wr[idx]));
    check({name, "_rd"}, 32'(rd_a), 32'(exp_rd[idx]));
  endtask

  // Stop dut_a and wait (bounded) for it to leave RUN/STOPPING, then one idle cycle.
  task automatic stop_and_drain(input string name);
    int k;
    k = 0;
    stop_ctrl = 1'b1;
    tick();
    stop_ctrl = 1'b0;
    while (busy_a && k < 16) begin
      tick();
      k++;
    end
    check({name, "_drained"}, 32'(busy_a), 32'(0));
    tick();
  endtask

  initial begin
    int cnt;
    exp_wr = '{2'b01, 2'b00, 2'b10, 2'b00};
    exp_rd = '{2'b00, 2'b01, 2'b00, 2'b10};
    //           stop  wr     rd     step  iter   busy  chk_s chk_b
    vecs[0]  = '{1'b0, 2'b01, 2'b00, 2'd0, 16'd0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 2'b00, 2'b01, 2'd1, 16'd0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 2'b10, 2'b00, 2'd2, 16'd0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 2'b00, 2'b10, 2'd3, 16'd1, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 2'b01, 2'b00, 2'd0, 16'd1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 2'b00, 2'b01, 2'd1, 16'd1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 2'b10, 2'b00, 2'd2, 16'd1, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 2'b00, 2'b10, 2'd3, 16'd2, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 2'b01, 2'b00, 2'd0, 16'd2, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 2'b00, 2'b01, 2'd1, 16'd2, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 2'b10, 2'b00, 2'd2, 16'd2, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 2'b00, 2'b10, 2'd3, 16'd3, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 2'b00, 2'd0, 16'd3, 1'b0, 1'b0, 1'b1};

    rst = 1'b0; load_ctrl = 1'b0; start_ctrl = 1'b0; stop_ctrl = 1'b0; ctrl_in = '0;
    #12;
    check("rst_wr", 32'(wr_a), 32'(0));
    check("rst_rd", 32'(rd_a), 32'(0));
    check("rst_busy", 32'(busy_a), 32'(0));
    check("rst_valid", 32'(valid_a), 32'(0));
    check("rst_err", 32'(err_a), 32'(0));
    check("rst_iter", 32'(iter_a), 32'(0));
    check("rst_step", 32'(step_a), 32'(0));
    #4 rst = 1'b1;
    tick();

    // Load, start, replay, stop mid-iteration.
    load_word(4'h1);
    load_word(4'h2);
    load_word(4'h4);
    check("t1_valid_before_last", 32'(valid_a), 32'(0));
    load_word(4'h8);
    check("t1_valid_after_last", 32'(valid_a), 32'(1));
    pulse_start();
    check("t1_e0_busy", 32'(busy_a), 32'(1));
    check("t1_e0_wr", 32'(wr_a), 32'(0));
    check("t1_e0_rd", 32'(rd_a), 32'(0));
    for (int i = 0; i < 13; i++) begin
      stop_ctrl = vecs[i].stop;
      tick();
      stop_ctrl = 1'b0;
      check($sformatf("t1_e%0d_wr", i + 1), 32'(wr_a), 32'(vecs[i].wr));
      check($sformatf("t1_e%0d_rd", i + 1), 32'(rd_a), 32'(vecs[i].rd));
      check($sformatf("t1_e%0d_iter", i + 1), 32'(iter_a), 32'(vecs[i].iter));
      if (vecs[i].chk_stp) check($sformatf("t1_e%0d_step", i + 1), 32'(step_a), 32'(vecs[i].stp));
      if (vecs[i].chk_bsy) check($sformatf("t1_e%0d_busy", i + 1), 32'(busy_a), 32'(vecs[i].bsy));
    end
    check("t1_err", 32'(err_a), 32'(0));

    // Stop sampled on the last-step edge ends right after that word.
    pulse_start();
    tick(); check_word("t2b_e1", 0);
    tick(); check_word("t2b_e2", 1);
    tick(); check_word("t2b_e3", 2);
    check("t2b_e3_busy", 32'(busy_a), 32'(1));
    stop_ctrl = 1'b1;
    tick();
    stop_ctrl = 1'b0;
    check_word("t2b_e4", 3);
    check("t2b_e4_iter", 32'(iter_a), 32'(1));
    tick();
    check("t2b_e5_wr", 32'(wr_a), 32'(0));
    check("t2b_e5_rd", 32'(rd_a), 32'(0));
    check("t2b_e5_busy", 32'(busy_a), 32'(0));

    // Bounded run on dut_b: exactly two iterations; dut_a keeps running.
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if ((wr_b | rd_b) != 2'b00) cnt++;
    end
    check("t3_toggle_cycles", 32'(cnt), 32'(8));
    check("t3_iter_b", 32'(iter_b), 32'(2));
    check("t3_busy_b", 32'(busy_b), 32'(0));
    check("t3_wr_b_idle", 32'(wr_b), 32'(0));
    check("t3_iter_a", 32'(iter_a), 32'(3));
    check("t3_busy_a", 32'(busy_a), 32'(1));
    stop_and_drain("t3_stop_a");
    check("t3_iter_a_final", 32'(iter_a), 32'(4));
    check("t3_wr_a_idle", 32'(wr_a), 32'(0));

    // Start without a table.
    do_reset();
    check("t4_valid_after_rst", 32'(valid_a), 32'(0));
    check("t4_err_after_rst", 32'(err_a), 32'(0));
    pulse_start();
    check("t4_err_set", 32'(err_a), 32'(1));
    check("t4_busy", 32'(busy_a), 32'(0));
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ((wr_a | rd_a) != 2'b00) cnt++;
    end
    check("t4_no_pulses", 32'(cnt), 32'(0));

    // Load during RUN is rejected and the run continues unchanged.
    do_reset();
    load_table();
    check("t4b_err_clear", 32'(err_a), 32'(0));
    pulse_start();
    tick();
    tick();
    load_ctrl = 1'b1;
    ctrl_in   = 4'hF;
    tick();
    load_ctrl = 1'b0;
    ctrl_in   = '0;
    check("t4b_err_set", 32'(err_a), 32'(1));
    check("t4b_busy", 32'(busy_a), 32'(1));
    check_word("t4b_e3", 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_word($sformatf("t4b_iter1_w%0d", i), i);
    end
    stop_and_drain("t4b_stop");

    // Load with a gap, then an aborted reload.
    do_reset();
    load_word(4'h1);
    load_word(4'h2);
    tick(); tick(); tick();
    check("t5_valid_gap", 32'(valid_a), 32'(0));
    load_word(4'h4);
    check("t5_valid_3rd", 32'(valid_a), 32'(0));
    load_word(4'h8);
    check("t5_valid_4th", 32'(valid_a), 32'(1));
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_word($sformatf("t5_w%0d", i), i);
    end
    stop_and_drain("t5_stop");
    load_word(4'h1);
    load_word(4'h2);
    check("t5_valid_reload", 32'(valid_a), 32'(0));
    stop_ctrl = 1'b1;
    tick();
    stop_ctrl = 1'b0;
    check("t5_valid_abort", 32'(valid_a), 32'(0));
    check("t5_err_before", 32'(err_a), 32'(0));
    pulse_start();
    check("t5_err_after", 32'(err_a), 32'(1));
    check("t5_busy_after", 32'(busy_a), 32'(0));

    // Asynchronous reset mid-run.
    do_reset();
    load_table();
    pulse_start();
    tick();
    tick();
    check("t6_pre_rd", 32'(rd_a), 32'(2'b01));
    check("t6_pre_step", 32'(step_a), 32'(1));
    #2 rst = 1'b0;
    #1;
    check("t6_async_rd", 32'(rd_a), 32'(0));
    check("t6_async_wr", 32'(wr_a), 32'(0));
    check("t6_async_busy", 32'(busy_a), 32'(0));
    check("t6_async_valid", 32'(valid_a), 32'(0));
    check("t6_async_step", 32'(step_a), 32'(0));
    #3 rst = 1'b1;
    tick();
    pulse_start();
    check("t6_err", 32'(err_a), 32'(1));
    tick();
    check("t6_no_pulse_wr", 32'(wr_a | rd_a), 32'(0));
    check("t6_busy", 32'(busy_a), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bdf_sched_seq.md
Name: bdf_sched_seq

Overview:
- Schedule sequencer for the BDF datapath. Holds a static per-iteration schedule table of ITER_PERIOD control words and replays it cyclically as per-buffer write/read ping-pong toggle pulses to the NUM_BUFFS buffer controllers.
- Sits between the host control interface (load/start/stop) and the buffer bank.
- Adds bounded iteration runs, graceful stop at the iteration boundary, an iteration counter and command-error reporting.

Parameters:
- NUM_BUFFS, 12, number of buffer controllers driven.
- CTRL_WIDTH, NUM_BUFFS*2, schedule word width. Bit 2i = wr toggle for buffer i; bit 2i+1 = rd toggle for buffer i.
- ITER_PERIOD, 48, schedule table depth (steps per iteration), >=2.
- MAX_ITERS, 0, iterations per run; 0 = run until stopped.
- STEP_W, $clog2(ITER_PERIOD), step index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- load_ctrl  in  1  write ctrl_in into the schedule table.
- start_ctrl  in  1  start a run.
- stop_ctrl  in  1  request stop / abort load.
- ctrl_in  in  CTRL_WIDTH  schedule word.
- buff_wr_toggle  out  NUM_BUFFS  one-cycle write-side swap pulses.
- buff_rd_toggle  out  NUM_BUFFS  one-cycle read-side swap pulses.
- step  out  STEP_W  index of the word currently on the toggle outputs.
- iter_cnt  out  16  completed iterations in the current/last run.
- busy  out  1  state is RUN or STOPPING.
- table_valid  out  1  full table loaded.
- cmd_err  out  1  sticky illegal-command flag.

Behaviour:

Reset:
- Asynchronous on rst=0: state IDLE, all outputs 0, wr_ptr 0, step 0.
- Table RAM contents are not reset; table_valid=0 marks them invalid.
- Reset asserted mid-run kills the toggle outputs immediately.

FSM states: IDLE, LOAD, RUN, STOPPING. Priority within a cycle: stop_ctrl > load_ctrl > start_ctrl.

IDLE:
- load_ctrl=1: write ctrl_in to entry 0, wr_ptr<=1, table_valid<=0, go to LOAD. A new load discards the previous table.
- start_ctrl=1 with table_valid=1: step<=0, iter_cnt<=0, go to RUN.
- start_ctrl=1 with table_valid=0: stay IDLE, cmd_err<=1.
- stop_ctrl=1: no effect, and it suppresses a simultaneous start.

LOAD:
- Each cycle with load_ctrl=1: table[wr_ptr]<=ctrl_in, wr_ptr++.
- load_ctrl=0: wr_ptr holds (gaps allowed).
- Writing entry ITER_PERIOD-1: table_valid<=1, wr_ptr<=0, go to IDLE.
- start_ctrl is ignored and sets cmd_err.
- stop_ctrl=1 aborts: go to IDLE, table_valid stays 0, wr_ptr<=0.

RUN:
- At each edge in RUN with step=k: buff_wr_toggle[i]<=table[k][2i], buff_rd_toggle[i]<=table[k][2i+1], step output<=k, then k advances.
- Wrap at k=ITER_PERIOD-1: next k=0 and iter_cnt increments (saturates at 16'hFFFF).
- If MAX_ITERS!=0 and the increment makes iter_cnt==MAX_ITERS: go to IDLE after the last word is emitted.
- stop_ctrl=1: go to STOPPING. If sampled on the step ITER_PERIOD-1 edge, go directly to IDLE instead.
- load_ctrl is ignored and sets cmd_err.

STOPPING:
- Continues stepping identically to RUN.
- After emitting word ITER_PERIOD-1 (iter_cnt increments): go to IDLE.
- stop_ctrl and start_ctrl are ignored.
- load_ctrl sets cmd_err.

Latency and output rules:
- start_ctrl sampled at edge E0: table[0] appears on the toggle outputs after edge E1.
- Back-to-back words thereafter, no bubbles, including across the wrap.
- Toggle outputs are 0 in every cycle not driven from a RUN/STOPPING step; they return to 0 the cycle after the final word.
- A partial iteration is never emitted on stop; only reset truncates.
- cmd_err is cleared only by reset.
- Table: ITER_PERIOD x CTRL_WIDTH register array or 1R1W RAM with a registered read. The 1-cycle read latency is absorbed by the output register.

Test Plan:
Bench configuration: NUM_BUFFS=2, ITER_PERIOD=4. Table words 4'h1, 4'h2, 4'h4, 4'h8 unless stated.

1. Load 4 words, then start.
   - table_valid=1 after the 4th write.
   - Outputs from E1: wr=01/rd=00, then wr=00/rd=01, then wr=10/rd=00, then wr=00/rd=10, repeating.
   - iter_cnt increments every 4 cycles; busy=1.
2. stop_ctrl pulsed at step 1 of iteration 2.
   - Remaining steps 2 and 3 are emitted, then outputs return to 0 and busy=0.
   - iter_cnt=3.
   - Repeat with stop at step 3: IDLE immediately after that word.
3. MAX_ITERS=2, start.
   - Exactly 8 toggle cycles, then IDLE with iter_cnt=2 and no stop needed.
4. start_ctrl with table_valid=0 (after reset) -> no pulses, cmd_err=1.
   - load_ctrl pulse during RUN -> table unchanged, cmd_err=1, run continues.
5. Load 2 words, drop load_ctrl 3 cycles, resume 2 words.
   - table_valid rises only after the 4th write.
   - stop_ctrl at wr_ptr=2 in a second load attempt -> table_valid=0, IDLE.
6. Assert rst low mid-RUN, asynchronously between edges.
   - All outputs 0 immediately; state IDLE; table_valid=0.
   - start_ctrl before reload -> cmd_err=1.
